// File: rtl/s1196_eval_ctrl_if.sv
// Requester handshakes, shared-cone operand/result and status of the s1196 evaluation controller.
// Pure wiring: no latency of its own.
// Backpressure lives in reqN_ready; the slave side is the controller.
interface s1196_eval_ctrl_if;
    logic        req0_valid;
    logic [17:0] req0_vec;
    logic        req0_ready;
    logic        req1_valid;
    logic [17:0] req1_vec;
    logic        req1_ready;
    logic [17:0] cone_vec;
    logic        cone_en;
    logic        cone_out;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_bit;
    logic [15:0] sig;
    logic [15:0] eval_cnt;
    logic        busy;

    modport slave (
        input  req0_valid, req0_vec, req1_valid, req1_vec, cone_out,
        output req0_ready, req1_ready, cone_vec, cone_en,
               rsp_valid, rsp_id, rsp_bit, sig, eval_cnt, busy
    );

    modport master (
        output req0_valid, req0_vec, req1_valid, req1_vec, cone_out,
        input  req0_ready, req1_ready, cone_vec, cone_en,
               rsp_valid, rsp_id, rsp_bit, sig, eval_cnt, busy
    );
endinterface

// File: rtl/s1196_eval_ctrl.sv
// Arbitrates two requesters onto one shared s1196 G542 cone and returns the sampled result with a MISR signature.
// Latency: accept at T, cone_en over T+1..T+SETTLE_CYC, rsp_valid at T+SETTLE_CYC+1.
// Backpressure: ready only in IDLE for the granted requester; others wait with ready low.
module s1196_eval_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic              CK,
    input  logic              RST,
    s1196_eval_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [17:0] cone_vec_q, cone_vec_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_bit_q, rsp_bit_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] eval_cnt_q, eval_cnt_d;
    logic        gnt0, gnt1;
    logic        fb;

    // Grant: single requester wins outright, a tie goes to the one not served last; nothing during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !RST) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    // Next state: load operand on acceptance, count settle cycles, capture result and signature on the last one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cone_vec_d   = cone_vec_q;
        rsp_id_d     = rsp_id_q;
        rsp_bit_d    = rsp_bit_q;
        last_grant_d = last_grant_q;
        sig_d        = sig_q;
        eval_cnt_d   = eval_cnt_q;
        fb           = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3] ^ bus.cone_out;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    cone_vec_d   = gnt1 ? bus.req1_vec : bus.req0_vec;
                    rsp_id_d     = gnt1;
                    last_grant_d = gnt1;
                    cnt_d        = 4'd0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_CNT) begin
                    rsp_bit_d = bus.cone_out;
                    sig_d     = {sig_q[14:0], fb};
                    if (eval_cnt_q != 16'hFFFF) begin
                        eval_cnt_d = eval_cnt_q + 16'd1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any acceptance or capture in the same cycle.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            cone_vec_q   <= 18'd0;
            rsp_id_q     <= 1'b0;
            rsp_bit_q    <= 1'b0;
            last_grant_q <= 1'b1;
            sig_q        <= 16'h0000;
            eval_cnt_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cone_vec_q   <= cone_vec_d;
            rsp_id_q     <= rsp_id_d;
            rsp_bit_q    <= rsp_bit_d;
            last_grant_q <= last_grant_d;
            sig_q        <= sig_d;
            eval_cnt_q   <= eval_cnt_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.cone_vec   = cone_vec_q;
    assign bus.cone_en    = (state_q == SETTLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_bit    = rsp_bit_q;
    assign bus.sig        = sig_q;
    assign bus.eval_cnt   = eval_cnt_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
